// File: rtl/iter_divider_pkg.sv
// iter_divider shared types: FSM state encoding and counter sizing.
// Build option: ITER_DIVIDER_SIGNED_EN selects two's complement operands.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package iter_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_divider_if.sv
// iter_divider handshake bundle: start/busy/done plus operands/results.
// master drives operands, slave is the divider.
interface iter_divider_if #(
  parameter int BUS_WIDTH = 16
);

  logic                 start;
  logic [BUS_WIDTH-1:0] ina;
  logic [BUS_WIDTH-1:0] inb;
  logic [BUS_WIDTH-1:0] quot;
  logic [BUS_WIDTH-1:0] rem;
  logic                 busy;
  logic                 done;
  logic                 divzero;

  modport master (
    output start, ina, inb,
    input  quot, rem, busy, done, divzero
  );

  modport slave (
    input  start, ina, inb,
    output quot, rem, busy, done, divzero
  );

endinterface

// File: rtl/iter_divider_div_step.sv
// iter_divider one-bit restoring step: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [BUS_WIDTH-1:0] divisor,
  output logic [BUS_WIDTH-1:0] rem_out,
  output logic                 qbit
);

  localparam int W = BUS_WIDTH;

  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic         borrow;
  logic         unused_bits;

  assign shifted = {rem_in, bit_in};

  // subtraction as a + ~b + 1; top bit is the borrow
  assign diff = {1'b0, shifted}
              + ~{2'b00, divisor}
              + {{(W+1){1'b0}}, 1'b1};

  assign borrow = diff[W+1];
  assign qbit   = ~borrow;

  // remainder after a step is always below the divisor, so W bits hold it
  assign rem_out = borrow ? shifted[W-1:0] : diff[W-1:0];

  assign unused_bits = ^{shifted[W], diff[W]};

endmodule

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring divider, one quotient bit per clock.
// Build option: ITER_DIVIDER_SIGNED_EN (signed operands, truncating).
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input logic          clk,
  input logic          reset,
  iter_divider_if.slave bus
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = `CLOG2(BUS_WIDTH);

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic [W-1:0]  pr;
  logic [W-1:0]  dvd;
  logic [W-1:0]  dsr;
  logic [W-1:0]  quot_q;
  logic [W-1:0]  rem_q;
  logic          divzero_q;
  logic          busy;
  logic          done;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W-1:0]  step_rem;
  logic          step_q;
  logic [W-1:0]  q_fin;
  logic [W-1:0]  q_fix;
  logic [W-1:0]  r_fix;
  logic          accept;
  logic          zero_b;

`ifdef ITER_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  div_step #(.BUS_WIDTH(W)) u_step (
    .rem_in (pr),
    .bit_in (dvd[W-1]),
    .divisor(dsr),
    .rem_out(step_rem),
    .qbit   (step_q)
  );

  assign accept = (state == ST_IDLE) && bus.start;
  assign zero_b = (bus.inb == '0);
  assign q_fin  = {dvd[W-2:0], step_q};

  // operand magnitudes fed to the unsigned datapath
  always_comb begin
    a_mag = bus.ina;
    b_mag = bus.inb;
`ifdef ITER_DIVIDER_SIGNED_EN
    if (bus.ina[W-1]) a_mag = ~bus.ina + 1'b1;
    if (bus.inb[W-1]) b_mag = ~bus.inb + 1'b1;
`endif
  end

  // sign correction of the final step result
  always_comb begin
    q_fix = q_fin;
    r_fix = step_rem;
`ifdef ITER_DIVIDER_SIGNED_EN
    if (neg_q) q_fix = ~q_fin + 1'b1;
    if (neg_r) r_fix = ~step_rem + 1'b1;
`endif
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start)
          state_nx = zero_b ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      pr        <= '0;
      dvd       <= '0;
      dsr       <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divzero_q <= 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else if (accept) begin
      pr        <= '0;
      dvd       <= a_mag;
      dsr       <= b_mag;
      cnt       <= CW'(W - 1);
      divzero_q <= zero_b;
`ifdef ITER_DIVIDER_SIGNED_EN
      neg_q     <= bus.ina[W-1] ^ bus.inb[W-1];
      neg_r     <= bus.ina[W-1];
`endif
      if (zero_b) begin
        quot_q <= '1;
        rem_q  <= bus.ina;
      end
    end else if (state == ST_CALC) begin
      pr  <= step_rem;
      dvd <= q_fin;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        quot_q <= q_fix;
        rem_q  <= r_fix;
      end
    end
  end

  assign bus.quot    = quot_q;
  assign bus.rem     = rem_q;
  assign bus.divzero = divzero_q;
  assign bus.busy    = busy;
  assign bus.done    = done;

endmodule
